// File: rtl/fetch_jump_seq.sv
// Purpose: control-step sequencer for instruction fetch followed by jr Ra (and jal Ra when JAL_EN is defined).
// Latency: start->done is 4*STEP_CYCLES+1 cycles for jr and 5*STEP_CYCLES+1 for jal, when mem_ready is high throughout fetch.
// Backpressure: start is accepted only in IDLE; T1 stalls on mem_ready and aborts with err after MEM_TIMEOUT cycles.
//
// Ports:
//   clk, reset          clock; asynchronous active-high reset
//   start               begin one fetch+execute sequence (IDLE only)
//   mem_ready           memory read data valid into MDR (waited on in T1)
//   ir_opcode[4:0]      ir[31:27], decoded at the end of T2
//   pc_out .. r_in      datapath control strobes, Moore outputs of the registered state
//   link_sel            forces register select to R15 during the jal link write
//   alu_op[3:0]         4'b0010 (Add) in T0, otherwise 4'b0000
//   busy / done / err   not-IDLE / one-cycle completion pulse / sticky error (cleared by next accepted start)
//
// Configuration macro: JAL_EN. When it is defined, OPC_JAL is decoded and the T4 link step is reachable.
// When it is undefined, OPC_JAL is an illegal opcode and link_sel is tied low.
module fetch_jump_seq #(
   parameter int unsigned STEP_CYCLES = 1,
   parameter int unsigned MEM_TIMEOUT = 15,
   parameter logic [4:0]  OPC_JR      = 5'b10011,
   parameter logic [4:0]  OPC_JAL     = 5'b10100
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       mem_ready,
   input  logic [4:0] ir_opcode,
   output logic       pc_out,
   output logic       mar_in,
   output logic       inc_pc,
   output logic       z_in,
   output logic       z_low_out,
   output logic       pc_in,
   output logic       read,
   output logic       mdr_in,
   output logic       mdr_out,
   output logic       ir_in,
   output logic       gra,
   output logic       r_out,
   output logic       r_in,
   output logic       link_sel,
   output logic [3:0] alu_op,
   output logic       busy,
   output logic       done,
   output logic       err
);

   localparam int unsigned SW = $clog2(STEP_CYCLES + 1);
   localparam int unsigned WW = $clog2(MEM_TIMEOUT + 1);
   localparam logic [SW-1:0] STEP_LAST = SW'(STEP_CYCLES - 1);
   localparam logic [SW-1:0] STEP_SAT  = SW'(STEP_CYCLES);
   localparam logic [WW-1:0] WAIT_LAST = WW'(MEM_TIMEOUT - 1);
   localparam logic [3:0]    ALU_ADD   = 4'b0010;

   typedef enum logic [2:0] {
      S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_FIN
   } state_t;

   state_t        state, state_nxt;
   logic [SW-1:0] step_cnt;
   logic [WW-1:0] wait_cnt;
   logic          err_q;
   logic          err_set;
   logic          step_last;
   logic          step_held;

   // step_cnt restarts on every state change and saturates at STEP_CYCLES, so in T1
   // it also marks when the first STEP_CYCLES cycles (the PC load window) are over.
   assign step_last = (step_cnt == STEP_LAST);
   assign step_held = (step_cnt >= STEP_LAST);
   assign err       = err_q;

   // State register and counters
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= S_IDLE;
         step_cnt <= '0;
         wait_cnt <= '0;
         err_q    <= 1'b0;
      end else begin
         state <= state_nxt;
         if (state_nxt != state)
            step_cnt <= '0;
         else if (step_cnt != STEP_SAT)
            step_cnt <= step_cnt + SW'(1);
         // Number of T1 cycles already spent; bounded by MEM_TIMEOUT-1 because T1 exits at WAIT_LAST.
         if (state == S_T1 && state_nxt == S_T1)
            wait_cnt <= wait_cnt + WW'(1);
         else
            wait_cnt <= '0;
         if (state == S_IDLE && start)
            err_q <= 1'b0;
         else if (err_set)
            err_q <= 1'b1;
      end
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      err_set   = 1'b0;
      case (state)
         S_IDLE: if (start) state_nxt = S_T0;
         S_T0:   if (step_last) state_nxt = S_T1;
         S_T1: begin
            // A ready memory on the last allowed cycle takes priority over the timeout.
            if (step_held && mem_ready) begin
               state_nxt = S_T2;
            end else if (wait_cnt == WAIT_LAST) begin
               state_nxt = S_FIN;
               err_set   = 1'b1;
            end
         end
         S_T2: begin
            if (step_last) begin
               if (ir_opcode == OPC_JR) begin
                  state_nxt = S_T3;
`ifdef JAL_EN
               end else if (ir_opcode == OPC_JAL) begin
                  state_nxt = S_T4;
`else
               end else if (ir_opcode == OPC_JAL) begin
                  // jal not supported in this build: illegal opcode
                  state_nxt = S_FIN;
                  err_set   = 1'b1;
`endif
               end else begin
                  state_nxt = S_FIN;
                  err_set   = 1'b1;
               end
            end
         end
`ifdef JAL_EN
         S_T4:   if (step_last) state_nxt = S_T3;
`endif
         S_T3:   if (step_last) state_nxt = S_FIN;
         S_FIN:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Output decode: pure function of registered state, so reset clears every strobe asynchronously.
   always_comb begin
      pc_out    = 1'b0;
      mar_in    = 1'b0;
      inc_pc    = 1'b0;
      z_in      = 1'b0;
      z_low_out = 1'b0;
      pc_in     = 1'b0;
      read      = 1'b0;
      mdr_in    = 1'b0;
      mdr_out   = 1'b0;
      ir_in     = 1'b0;
      gra       = 1'b0;
      r_out     = 1'b0;
      r_in      = 1'b0;
      link_sel  = 1'b0;
      alu_op    = 4'b0000;
      busy      = (state != S_IDLE);
      done      = (state == S_FIN);
      case (state)
         S_T0: begin
            pc_out = 1'b1;
            mar_in = 1'b1;
            inc_pc = 1'b1;
            z_in   = 1'b1;
            alu_op = ALU_ADD;
         end
         S_T1: begin
            z_low_out = 1'b1;
            pc_in     = (step_cnt != STEP_SAT); // PC loads only during the first step
            read      = 1'b1;
            mdr_in    = 1'b1;
         end
         S_T2: begin
            mdr_out = 1'b1;
            ir_in   = 1'b1;
         end
`ifdef JAL_EN
         S_T4: begin
            pc_out   = 1'b1;
            r_in     = 1'b1;
            link_sel = 1'b1;
         end
`endif
         S_T3: begin
            gra   = 1'b1;
            r_out = 1'b1;
            pc_in = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_fetch_jump_seq.sv
// Bench for fetch_jump_seq: STEP_CYCLES=2, MEM_TIMEOUT=7.
module tb_fetch_jump_seq;

   localparam int         S       = 2;
   localparam int         MT      = 7;
   localparam logic [4:0] OPC_JR  = 5'b10011;
   localparam logic [4:0] OPC_JAL = 5'b10100;

   // Output vector layout
   localparam int P_PC_OUT  = 20;
   localparam int P_MAR_IN  = 19;
   localparam int P_INC_PC  = 18;
   localparam int P_Z_IN    = 17;
   localparam int P_Z_LOW   = 16;
   localparam int P_PC_IN   = 15;
   localparam int P_READ    = 14;
   localparam int P_MDR_IN  = 13;
   localparam int P_MDR_OUT = 12;
   localparam int P_IR_IN   = 11;
   localparam int P_GRA     = 10;
   localparam int P_R_OUT   = 9;
   localparam int P_R_IN    = 8;
   localparam int P_LINK    = 7;
   localparam int P_BUSY    = 2;
   localparam int P_DONE    = 1;
   localparam int P_ERR     = 0;

   logic       clk = 1'b0;
   logic       reset, start, mem_ready;
   logic [4:0] ir_opcode;
   logic       pc_out, mar_in, inc_pc, z_in, z_low_out, pc_in, read, mdr_in;
   logic       mdr_out, ir_in, gra, r_out, r_in, link_sel, busy, done, err;
   logic [3:0] alu_op;
   logic [20:0] dut_vec;

   int checks   = 0;
   int failures = 0;
   bit err_state = 1'b0;
   logic [20:0] tq[$];
   int t1len;

   always #5 clk = ~clk;

   fetch_jump_seq #(
      .STEP_CYCLES(S),
      .MEM_TIMEOUT(MT),
      .OPC_JR(OPC_JR),
      .OPC_JAL(OPC_JAL)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .mem_ready(mem_ready), .ir_opcode(ir_opcode),
      .pc_out(pc_out), .mar_in(mar_in), .inc_pc(inc_pc), .z_in(z_in), .z_low_out(z_low_out),
      .pc_in(pc_in), .read(read), .mdr_in(mdr_in), .mdr_out(mdr_out), .ir_in(ir_in),
      .gra(gra), .r_out(r_out), .r_in(r_in), .link_sel(link_sel), .alu_op(alu_op),
      .busy(busy), .done(done), .err(err)
   );

   assign dut_vec = {pc_out, mar_in, inc_pc, z_in, z_low_out, pc_in, read, mdr_in, mdr_out,
                     ir_in, gra, r_out, r_in, link_sel, alu_op, busy, done, err};

   // Reference model: expected output trace of one sequence, one entry per cycle from T0 to FIN.
   // Memory is ready from T1 cycle index d onward (index 0 = first T1 cycle).
   task automatic build(input logic [4:0] opc, input int d, output bit e);
      logic [20:0] v;
      int ex;
      bit fetched;
      tq.delete();
      e = 1'b0;
      for (int i = 0; i < S; i++) begin
         v = '0; v[P_BUSY] = 1'b1;
         v[P_PC_OUT] = 1'b1; v[P_MAR_IN] = 1'b1; v[P_INC_PC] = 1'b1; v[P_Z_IN] = 1'b1;
         v[6:3] = 4'b0010;
         tq.push_back(v);
      end
      ex = (d > S - 1) ? d : S - 1;
      fetched = (ex <= MT - 1);
      t1len = fetched ? ex + 1 : MT;
      for (int i = 0; i < t1len; i++) begin
         v = '0; v[P_BUSY] = 1'b1;
         v[P_Z_LOW] = 1'b1; v[P_READ] = 1'b1; v[P_MDR_IN] = 1'b1;
         v[P_PC_IN] = (i < S);
         tq.push_back(v);
      end
      if (!fetched) begin
         e = 1'b1;
      end else begin
         for (int i = 0; i < S; i++) begin
            v = '0; v[P_BUSY] = 1'b1; v[P_MDR_OUT] = 1'b1; v[P_IR_IN] = 1'b1;
            tq.push_back(v);
         end
`ifdef JAL_EN
         if (opc == OPC_JAL) begin
            for (int i = 0; i < S; i++) begin
               v = '0; v[P_BUSY] = 1'b1; v[P_PC_OUT] = 1'b1; v[P_R_IN] = 1'b1; v[P_LINK] = 1'b1;
               tq.push_back(v);
            end
         end
         if (opc == OPC_JR || opc == OPC_JAL) begin
`else
         if (opc == OPC_JR) begin
`endif
            for (int i = 0; i < S; i++) begin
               v = '0; v[P_BUSY] = 1'b1; v[P_GRA] = 1'b1; v[P_R_OUT] = 1'b1; v[P_PC_IN] = 1'b1;
               tq.push_back(v);
            end
         end else begin
            e = 1'b1;
         end
      end
      v = '0; v[P_BUSY] = 1'b1; v[P_DONE] = 1'b1; v[P_ERR] = e;
      tq.push_back(v);
   endtask

   task automatic cmp(input string name, input logic [20:0] exp);
      checks++;
      if (dut_vec !== exp) begin
         failures++;
         $display("FAIL %s t=%0t outputs=%h expected=%h", name, $time, dut_vec, exp);
      end
      checks++;
      if ($countones({pc_out, z_low_out, mdr_out, r_out}) > 1) begin
         failures++;
         $display("FAIL bus_excl t=%0t bus_drivers=%b expected at most one", $time,
                  {pc_out, z_low_out, mdr_out, r_out});
      end
   endtask

   task automatic pin(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   // Drives one full sequence and checks every cycle plus a short idle gap afterwards.
   // lit_done > 0 additionally pins the cycle (1 = first T0 cycle) where done must be seen.
   task automatic run_txn(input logic [4:0] opc, input int d, input int lit_done);
      bit e;
      logic [20:0] idle_v;
      int gap;
      build(opc, d, e);
      start = 1'b1;
      ir_opcode = opc;
      mem_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      for (int k = 0; k < tq.size(); k++) begin
         start = 1'($urandom_range(0, 1));
         if (k >= S && k < S + t1len) mem_ready = (k - S >= d);
         else mem_ready = 1'($urandom_range(0, 1));
         @(negedge clk);
         cmp("seq", tq[k]);
         if (lit_done > 0 && k == lit_done - 1) begin
            checks++;
            if (done !== 1'b1) begin
               failures++;
               $display("FAIL done_cycle cycle=%0d done=%b expected=1", lit_done, done);
            end
         end
         @(posedge clk); #1;
      end
      err_state = e;
      start = 1'b0;
      idle_v = '0; idle_v[P_ERR] = err_state;
      gap = 1 + $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
         @(negedge clk);
         cmp("idle", idle_v);
         @(posedge clk); #1;
      end
   endtask

   initial begin
      bit e;
      logic [20:0] v;
      logic [4:0] opc;
      int sel;
      reset = 1'b1; start = 1'b1; mem_ready = 1'b0; ir_opcode = OPC_JR;

      // Reset held with start high: everything stays low.
      repeat (3) @(posedge clk);
      @(negedge clk);
      cmp("reset_hold", '0);
      @(posedge clk); #1;
      reset = 1'b0;

      // Hand-computed trace lengths that pin the model (S=2, MT=7).
      build(OPC_JR, 0, e);       pin("len_jr", tq.size(), 9);
      pin("err_jr", int'(e), 0);
      build(OPC_JR, 3, e);       pin("len_jr_wait3", tq.size(), 11);
      build(OPC_JR, MT + 5, e);  pin("len_timeout", tq.size(), 10);
      pin("err_timeout", int'(e), 1);
      build(OPC_JR, MT - 1, e);  pin("len_last_ready", tq.size(), 14);
      build(5'b00001, 0, e);     pin("len_illegal", tq.size(), 7);
      pin("err_illegal", int'(e), 1);
      pin("t1_pcin_first", int'(tq[2][P_PC_IN]), 1);
      pin("t1_pcin_third", int'(tq[4][P_PC_IN]), 0);

      run_txn(OPC_JR, 0, 9);          // start held across reset release
      run_txn(OPC_JR, 3, 11);         // T1 stretched to 4 cycles
      run_txn(OPC_JR, MT + 5, 10);    // timeout, err stays set in IDLE
      run_txn(OPC_JR, 0, 9);          // err cleared by the accepted start
      run_txn(OPC_JR, MT - 1, 14);    // ready on the final allowed cycle wins
`ifdef JAL_EN
      run_txn(OPC_JAL, 0, 11);
`else
      run_txn(OPC_JAL, 0, 7);
`endif
      run_txn(5'b00001, 1, 7);

      // Reset asserted mid-T1: outputs drop inside the same cycle, no done pulse.
      start = 1'b1; ir_opcode = OPC_JR; mem_ready = 1'b0;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (S) @(posedge clk);
      #1;
      v = '0; v[P_BUSY] = 1'b1; v[P_Z_LOW] = 1'b1; v[P_READ] = 1'b1; v[P_MDR_IN] = 1'b1;
      v[P_PC_IN] = 1'b1;
      cmp("pre_reset_t1", v);
      #1 reset = 1'b1;
      #1 cmp("reset_async", '0);
      @(posedge clk); #1;
      reset = 1'b0;
      err_state = 1'b0;
      for (int g = 0; g < 2; g++) begin
         @(negedge clk);
         cmp("post_reset_idle", '0);
         @(posedge clk); #1;
      end
      run_txn(OPC_JR, 2, 0);

      // Randomized sequences.
      for (int n = 0; n < 40; n++) begin
         sel = $urandom_range(0, 3);
         if (sel < 2) opc = OPC_JR;
         else if (sel == 2) opc = OPC_JAL;
         else opc = 5'($urandom);
         run_txn(opc, $urandom_range(0, MT + 2), 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
